// File: rtl/manchester_spi_rx_pkg.sv
// Shared types and constants for the Manchester-coded SPI receiver.
package manchester_spi_rx_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned ERR_CNT_W  = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

    // Decoder states: first half expected (H1), second half expected (H2),
    // DRAIN swallows the rest of a frame after a line-code violation.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        H1    = 2'd1,
        H2    = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/manchester_spi_rx_if.sv
// Valid/ready byte bus between the receiver and its consumer.
interface manchester_spi_rx_if
    import manchester_spi_rx_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) ();

    logic [DATA_W-1:0] data_out;
    logic              valid;
    logic              ready;

    modport master (output data_out, output valid, input ready);
    modport slave  (input data_out, input valid, output ready);

endinterface

// File: rtl/manchester_spi_rx_holdreg.sv
// One-entry valid/ready holding register; flags bytes dropped while full.
module spi_rx_holdreg
    import manchester_spi_rx_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              overrun
);

    // Load when empty or being drained this edge; otherwise keep old byte and pulse overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            valid    <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                if (!valid || ready) begin
                    data_out <= load_data;
                    valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/manchester_spi_rx.sv
// Manchester-coded serial receiver: decodes 2-cycle symbols LSB first into bytes,
// detects line-code, framing and overrun errors and keeps a saturating error count.
module manchester_spi_rx
    import manchester_spi_rx_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sdi,
    input  logic                  en_in,
    manchester_spi_rx_if.master   bus,
    output logic                  sym_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic [ERR_CNT_W-1:0]  err_count
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic              r_sdi;
    logic              r_en;
    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic              h1;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] byte_c;
    logic              done_c;
    logic [DATA_W-1:0] hr_data;
    logic              hr_valid;

    // Single input register stage; the decoder only looks at r_sdi/r_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sdi <= 1'b0;
            r_en  <= 1'b0;
        end else begin
            r_sdi <= sdi;
            r_en  <= en_in;
        end
    end

    // Byte as it would look with the current bit merged in, and its completion strobe.
    always_comb begin
        byte_c          = shreg;
        byte_c[bit_cnt] = h1;
        done_c          = (state == H2) && r_en && (r_sdi != h1) && (bit_cnt == LAST_BIT);
    end

    // Symbol decoder FSM with registered sym_err/frame_err pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            h1        <= 1'b0;
            shreg     <= '0;
            sym_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sym_err   <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (r_en) begin
                        h1      <= r_sdi;
                        bit_cnt <= '0;
                        state   <= H2;
                    end
                end
                H1: begin
                    if (!r_en) begin
                        if (bit_cnt != '0) begin
                            frame_err <= 1'b1;
                        end
                        bit_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        h1    <= r_sdi;
                        state <= H2;
                    end
                end
                H2: begin
                    if (!r_en) begin
                        frame_err <= 1'b1;
                        bit_cnt   <= '0;
                        state     <= IDLE;
                    end else if (r_sdi == h1) begin
                        sym_err <= 1'b1;
                        bit_cnt <= '0;
                        state   <= DRAIN;
                    end else begin
                        shreg <= byte_c;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                        state <= H1;
                    end
                end
                DRAIN: begin
                    if (!r_en) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    spi_rx_holdreg #(
        .DATA_W (DATA_W)
    ) u_holdreg (
        .clk       (clk),
        .rst       (rst),
        .load      (done_c),
        .load_data (byte_c),
        .ready     (bus.ready),
        .data_out  (hr_data),
        .valid     (hr_valid),
        .overrun   (overrun)
    );

    assign bus.data_out = hr_data;
    assign bus.valid    = hr_valid;

    // Saturating count of error pulses; the three pulses never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if ((sym_err || frame_err || overrun) && (err_count != ERR_CNT_MAX)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_manchester_spi_rx.sv
// Scoreboard bench for manchester_spi_rx: directed frames, queued expected bytes,
// a negedge monitor popping on every handshake and counting error pulses.
module tb_manchester_spi_rx;
    import manchester_spi_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       sdi;
    logic       en_in;
    logic       sym_err;
    logic       frame_err;
    logic       overrun;
    logic [7:0] err_count;

    manchester_spi_rx_if #(.DATA_W(8)) bus ();

    manchester_spi_rx #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sdi       (sdi),
        .en_in     (en_in),
        .bus       (bus),
        .sym_err   (sym_err),
        .frame_err (frame_err),
        .overrun   (overrun),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_sym = 0, n_frm = 0, n_ovr = 0;
    int exp_sym = 0, exp_frm = 0, exp_ovr = 0;
    int cyc = 0;
    int last_hs = -1;
    int hs_gap = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts error pulses and checks every accepted byte against the queue.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (sym_err)   n_sym++;
                if (frame_err) n_frm++;
                if (overrun)   n_ovr++;
                if (bus.valid && bus.ready) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_byte: got %0h expected none (t=%0t)", bus.data_out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.data_out !== e) begin
                            n_err++;
                            $display("FAIL byte: got %0h expected %0h (t=%0t)", bus.data_out, e, $time);
                        end
                    end
                    if (last_hs >= 0) hs_gap = cyc - last_hs;
                    last_hs = cyc;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic send_bit(input logic b);
        en_in = 1'b1;
        sdi   = b;
        tick();
        sdi   = ~b;
        tick();
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, input bit push);
        for (int i = 0; i < n; i++) send_bit(v[i]);
        if (push) exp_q.push_back(v);
    endtask

    task automatic idle(input int n);
        en_in = 1'b0;
        sdi   = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        en_in = 1'b0;
        sdi   = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_sym_pulses"}, 32'(n_sym), 32'(exp_sym));
        check({tag, "_frame_pulses"}, 32'(n_frm), 32'(exp_frm));
        check({tag, "_ovr_pulses"}, 32'(n_ovr), 32'(exp_ovr));
    endtask

    initial begin
        rst       = 1'b1;
        sdi       = 1'b0;
        en_in     = 1'b0;
        bus.ready = 1'b1;
        tick();
        check("rst_data", 32'(bus.data_out), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_errs", {29'h0, sym_err, frame_err, overrun}, 32'h0);
        check("rst_err_count", 32'(err_count), 32'h0);
        rst = 1'b0;
        tick();

        // 0xA5 single frame with latency checks
        send_bits(8'hA5, 8, 1'b1);
        en_in = 1'b0;
        check("a5_pre_valid", 32'(bus.valid), 32'h0);
        tick();
        check("a5_valid", 32'(bus.valid), 32'h1);
        check("a5_data", 32'(bus.data_out), 32'hA5);
        tick();
        check("a5_valid_fall", 32'(bus.valid), 32'h0);
        idle(3);
        check("a5_err_count", 32'(err_count), 32'h0);

        // 0x3C, 0xC3 back to back
        send_bits(8'h3C, 8, 1'b1);
        send_bits(8'hC3, 8, 1'b1);
        idle(5);
        check("b2b_gap", 32'(hs_gap), 32'd16);
        check("b2b_err_count", 32'(err_count), 32'h0);
        check_counts("b2b");

        // 0x5A with bit 2 sent as 11, then a clean 0x5A
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                en_in = 1'b1;
                sdi = 1'b1; tick();
                sdi = 1'b1; tick();
            end else begin
                send_bit(logic'((8'h5A >> i) & 8'h1));
            end
        end
        exp_sym++;
        idle(4);
        check("sym_valid", 32'(bus.valid), 32'h0);
        send_bits(8'h5A, 8, 1'b1);
        idle(4);
        check("sym_err_count", 32'(err_count), 32'h1);
        check_counts("sym");

        // en_in dropped after 5 bits, then 0x81
        do_reset();
        send_bits(8'hFF, 5, 1'b0);
        exp_frm++;
        idle(4);
        check("frm_err_count", 32'(err_count), 32'h1);
        send_bits(8'h81, 8, 1'b1);
        idle(4);
        check_counts("frm");

        // overrun with ready low
        do_reset();
        bus.ready = 1'b0;
        send_bits(8'h11, 8, 1'b1);
        idle(3);
        send_bits(8'h22, 8, 1'b0);
        exp_ovr++;
        idle(4);
        check("ovr_valid", 32'(bus.valid), 32'h1);
        check("ovr_data", 32'(bus.data_out), 32'h11);
        check("ovr_err_count", 32'(err_count), 32'h1);
        check_counts("ovr");
        bus.ready = 1'b1;
        tick();
        check("ovr_consumed", 32'(bus.valid), 32'h0);

        // asynchronous reset mid-byte
        do_reset();
        bus.ready = 1'b0;
        send_bits(8'h07, 3, 1'b0);
        exp_frm++;
        idle(4);
        send_bits(8'h11, 8, 1'b0);
        idle(3);
        send_bits(8'h33, 4, 1'b0);
        check("prerst_valid", 32'(bus.valid), 32'h1);
        check("prerst_err_count", 32'(err_count), 32'h1);
        rst   = 1'b1;
        en_in = 1'b0;
        #1;
        check("arst_data", 32'(bus.data_out), 32'h0);
        check("arst_valid", 32'(bus.valid), 32'h0);
        check("arst_err_count", 32'(err_count), 32'h0);
        check("arst_pulses", {29'h0, sym_err, frame_err, overrun}, 32'h0);
        tick();
        rst = 1'b0;
        bus.ready = 1'b1;
        tick();
        send_bits(8'h81, 8, 1'b1);
        idle(4);
        check("postrst_err_count", 32'(err_count), 32'h0);
        check_counts("arst");

        // error counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            en_in = 1'b1;
            sdi = 1'b1; tick();
            sdi = 1'b1; tick();
            en_in = 1'b0;
            tick();
            tick();
            if (i == 253) begin
                idle(3);
                check("sat_254", 32'(err_count), 32'd254);
            end
        end
        exp_sym += 300;
        idle(3);
        check("sat_255", 32'(err_count), 32'd255);
        check_counts("sat");
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
